spi_xfer_engine: RTL and testbench

Bit-level SPI mode-0 shift engine that sits directly downstream of the SPI master sequencer and drives the flash pins (SPI_CLK, SPI_MOSI, SPI_CS_N, SPI_MISO). The sequencer hands it one 1–4 byte word per start pulse. The engine generates SCK from the divided system clock, shifts the word out MSB-first while sampling MISO, and returns the received word with a one-cycle done pulse. Chip select can be held across words so multi-word flash commands (opcode, address, data) form one CS frame.

---
 rtl/spi_xfer_pkg.sv | 20 ++
 rtl/spi_xfer_engine_spi_clk_gen.sv | 29 ++
 rtl/spi_xfer_engine.sv | 116 +++++++++++
 tb/tb_spi_xfer_engine.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_xfer_pkg.sv
// rtl/spi_xfer_pkg.sv - shared states, limits and helpers for the SPI transfer engine
package spi_xfer_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_TAIL  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int MAX_BYTES   = 4;
  localparam int DEFAULT_DIV = 2;

  // Byte counts 1..MAX_BYTES pass through; 0 and anything larger mean a full word
  function automatic logic [2:0] decode_nbytes(input logic [2:0] n);
    if (n == 3'd0 || n > 3'(MAX_BYTES)) return 3'(MAX_BYTES);
    return n;
  endfunction

endpackage

// File: rtl/spi_xfer_engine_spi_clk_gen.sv
// rtl/spi_xfer_engine_spi_clk_gen.sv - half-period tick generator for the SPI shift engine
module spi_clk_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] RELOAD = 8'(DIV - 1);

  logic [7:0] cnt;

  assign tick = en && (cnt == 8'd0);

  // Count down while enabled; park at the reload value while idle so every
  // phase starts with a full DIV-cycle interval
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= RELOAD;
    end else if (!en || cnt == 8'd0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 8'd1;
    end
  end

endmodule

// File: rtl/spi_xfer_engine.sv
// rtl/spi_xfer_engine.sv - SPI mode-0 word shift engine; SPI_XFER_LOOPBACK_EN routes spi_mosi into the rx path
module spi_xfer_engine
  import spi_xfer_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] tx_data,
  input  logic [2:0]  nbytes,
  input  logic        hold_cs,
  output logic        busy,
  output logic        done,
  output logic [31:0] rx_data,
  output logic        spi_clk,
  output logic        spi_mosi,
  output logic        spi_csn,
  input  logic        spi_miso
);

  logic [2:0]  state;
  logic [31:0] tx_sh;
  logic [31:0] rx_sh;
  logic [5:0]  bits_left;
  logic        hold_q;
  logic        tick;
  logic        gen_en;
  logic        miso_src;
  logic [2:0]  nb_dec;
  logic [5:0]  nbits;

  assign nb_dec = decode_nbytes(nbytes);
  assign nbits  = {nb_dec, 3'b000};

  // tx word is kept left-aligned so the bit on the wire is always the top bit
  assign spi_mosi = tx_sh[31];

`ifdef SPI_XFER_LOOPBACK_EN
  assign miso_src = spi_mosi;
`else
  assign miso_src = spi_miso;
`endif

  assign gen_en = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_TAIL);

  spi_clk_gen #(.DIV(DIV)) u_clk_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (gen_en),
    .tick (tick)
  );

  // Word sequencing: latch on start, shift on SCK edges, publish result on DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      tx_sh     <= 32'd0;
      rx_sh     <= 32'd0;
      rx_data   <= 32'd0;
      bits_left <= 6'd0;
      hold_q    <= 1'b0;
      spi_clk   <= 1'b0;
      spi_csn   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            tx_sh     <= tx_data << (6'd32 - nbits);
            rx_sh     <= 32'd0;
            bits_left <= nbits;
            hold_q    <= hold_cs;
            spi_csn   <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tick) state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (tick) begin
            spi_clk <= ~spi_clk;
            if (!spi_clk) begin
              rx_sh <= {rx_sh[30:0], miso_src};
            end else if (bits_left == 6'd1) begin
              state <= ST_TAIL;
            end else begin
              tx_sh     <= {tx_sh[30:0], 1'b0};
              bits_left <= bits_left - 6'd1;
            end
          end
        end
        ST_TAIL: begin
          if (tick) begin
            state   <= ST_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
            rx_data <= rx_sh;
            spi_csn <= ~hold_q;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_engine.sv
// tb/tb_spi_xfer_engine.sv - self-checking bench for spi_xfer_engine
module tb_spi_xfer_engine;

  localparam int DIV = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] tx_data;
  logic [2:0]  nbytes;
  logic        hold_cs;
  logic        busy;
  logic        done;
  logic [31:0] rx_data;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_csn;
  logic        spi_miso;
  logic        miso_drv;
  logic        tie;

  int total = 0;
  int bad   = 0;
  int cyc = 0, rises = 0, all_rises = 0, done_cnt = 0, frame_csn_high = 0;
  int last_rise = -100, last_mchg = -100;
  logic prev_clk = 1'b0, prev_mosi = 1'b0;
  logic mosi_q[$];

  assign spi_miso = tie ? spi_mosi : miso_drv;

  always #5 clk = ~clk;

  spi_xfer_engine #(.DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .tx_data  (tx_data),
    .nbytes   (nbytes),
    .hold_cs  (hold_cs),
    .busy     (busy),
    .done     (done),
    .rx_data  (rx_data),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_csn  (spi_csn),
    .spi_miso (spi_miso)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Per-cycle pin monitor: records MOSI at each SCK rise and checks pin rules
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rst) begin
      if (busy) check("csn_low_while_busy", 32'(spi_csn), 32'd0);
      else      check("sck_low_while_idle", 32'(spi_clk), 32'd0);
      if (!done && spi_csn) frame_csn_high++;
      if (done) done_cnt++;
      if (spi_clk && !prev_clk) begin
        rises++;
        all_rises++;
        mosi_q.push_back(spi_mosi);
        check("mosi_setup_time", 32'(cyc - last_mchg >= DIV), 32'd1);
        last_rise = cyc;
      end
      if (busy && spi_mosi !== prev_mosi)
        check("mosi_hold_time", 32'(cyc - last_rise >= DIV), 32'd1);
      if (spi_mosi !== prev_mosi) last_mchg = cyc;
    end
    prev_clk  = spi_clk;
    prev_mosi = spi_mosi;
  end

  // mode: 0 = miso low, 1 = miso high, 2 = miso tied to mosi
  task automatic run_word(input logic [31:0] tx, input logic [2:0] nb, input logic hold,
                          input int mode, input int glitch_at, input logic clear_frame,
                          output int cycles, output logic [31:0] sent);
    int n, bits, lat, dc0;
    logic [31:0] mask, exp_rx;
    n    = (nb == 3'd0 || nb > 3'd4) ? 4 : int'(nb);
    bits = 8 * n;
    mask = (bits == 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
    tie      = (mode == 2);
    miso_drv = (mode == 1);
`ifdef SPI_XFER_LOOPBACK_EN
    exp_rx = tx & mask;
`else
    exp_rx = (mode == 2) ? (tx & mask) : ((mode == 1) ? mask : 32'd0);
`endif
    @(negedge clk);
    tx_data = tx;
    nbytes  = nb;
    hold_cs = hold;
    start   = 1'b1;
    rises   = 0;
    mosi_q.delete();
    dc0 = done_cnt;
    if (clear_frame) begin
      frame_csn_high = 0;
      all_rises = 0;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_csn", 32'(spi_csn), 32'd0);
    check("first_bit", 32'(spi_mosi), 32'(tx[bits-1]));
    lat = 0;
    while (done !== 1'b1 && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
      if (lat == glitch_at) begin
        tx_data = ~tx;
        nbytes  = 3'd1;
        start   = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    cycles = lat + 1;
    check("done_seen", 32'(done), 32'd1);
    check("latency", 32'(lat + 1), 32'(1 + DIV * (2 + 2 * bits)));
    check("sck_rises", 32'(rises), 32'(bits));
    sent = 32'd0;
    foreach (mosi_q[i]) sent = {sent[30:0], mosi_q[i]};
    check("mosi_word", sent, tx & mask);
    check("rx_data", rx_data, exp_rx);
    check("done_busy", 32'(busy), 32'd0);
    check("done_csn", 32'(spi_csn), 32'(!hold));
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("rx_hold", rx_data, exp_rx);
    if (glitch_at >= 0) begin
      repeat (60) @(posedge clk);
      #1;
      check("single_done", 32'(done_cnt - dc0), 32'd1);
      check("no_queued_word", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles, dc0;
    logic [31:0] sent;
    rst = 1'b1; start = 1'b0; tx_data = 32'd0; nbytes = 3'd1;
    hold_cs = 1'b0; miso_drv = 1'b0; tie = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_clk", 32'(spi_clk), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_csn", 32'(spi_csn), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rx", rx_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single byte, loopback tie: literal pins for the model
    run_word(32'h0000_00A5, 3'd1, 1'b0, 2, -1, 1'b1, cycles, sent);
    check("lit_a5_cycles", 32'(cycles), 32'd37);
    check("lit_a5_bits", sent, 32'h0000_00A5);
    check("lit_a5_rx", rx_data, 32'h0000_00A5);

    // Full word with miso high
    run_word(32'h1234_5678, 3'd4, 1'b0, 1, -1, 1'b1, cycles, sent);
    check("lit_w4_bits", sent, 32'h1234_5678);
    check("lit_w4_cycles", 32'(cycles), 32'd133);
`ifndef SPI_XFER_LOOPBACK_EN
    check("lit_w4_rx", rx_data, 32'hFFFF_FFFF);
`endif

    // Two-word CS frame: csn rises only in the final done cycle
    run_word(32'h0000_0003, 3'd1, 1'b1, 2, -1, 1'b1, cycles, sent);
    run_word(32'h0000_1000, 3'd3, 1'b0, 0, -1, 1'b0, cycles, sent);
    check("frame_rises", 32'(all_rises), 32'd32);
    check("frame_csn_high", 32'(frame_csn_high), 32'd1);

    // start pulsed mid-SHIFT is ignored
    run_word(32'h0000_005A, 3'd1, 1'b0, 2, 10, 1'b1, cycles, sent);
    check("lit_glitch_rx", rx_data, 32'h0000_005A);

    // Reset mid-word
    tie = 1'b0; miso_drv = 1'b1;
    @(negedge clk);
    tx_data = 32'h0000_BEEF; nbytes = 3'd2; hold_cs = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    dc0 = done_cnt;
    rst = 1'b1;
    #1;
    check("mid_rst_csn", 32'(spi_csn), 32'd1);
    check("mid_rst_clk", 32'(spi_clk), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rx", rx_data, 32'd0);
    check("mid_rst_mosi", 32'(spi_mosi), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    check("no_done_after_rst", 32'(done_cnt - dc0), 32'd0);
    run_word(32'h0000_00C3, 3'd1, 1'b0, 2, -1, 1'b1, cycles, sent);

    // nbytes decode: 0 and >4 mean four bytes
    run_word(32'h8000_0001, 3'd0, 1'b0, 0, -1, 1'b1, cycles, sent);
    check("lit_nb0_bits", sent, 32'h8000_0001);
`ifdef SPI_XFER_LOOPBACK_EN
    check("lit_nb0_rx_loop", rx_data, 32'h8000_0001);
`else
    check("lit_nb0_rx", rx_data, 32'd0);
`endif
    run_word(32'hF00D_CAFE, 3'd7, 1'b0, 1, -1, 1'b1, cycles, sent);
    run_word(32'h00AB_CDEF, 3'd2, 1'b0, 2, -1, 1'b1, cycles, sent);
    check("lit_nb2_bits", sent, 32'h0000_CDEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
